tdm_frame_gen: RTL
==================

// Module: tdm_frame_gen
// PURPOSE
//  Master-mode TDM/I2S frame timing generator. Consumes the decoded slot count (2/4/8/16) and a
//  BCLK divider. Produces BCLK, FSYNC and per-bit/per-slot position strobes. These drive the
//  i2s serializer/deserializer stages downstream. Configuration is applied only at frame boundaries.
// PARAMETERS
//  SLOT_BITS  32  bits per TDM slot; power of 2, 8..32
//  DIV_W      8   width of bclk_div
// PORTS
//  clk          in   1          system clock; all logic is on its rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  enable       in   1          run request (level)
//  bclk_div     in   DIV_W      BCLK half-period in clk cycles, minus 1
//  tdm_num      in   5          slots per frame; legal values 2, 4, 8, 16
//  fsync_mode   in   1          0: one-BCLK pulse; 1: 50% duty (high for first half of slots)
//  bclk         out  1          serial bit clock; data changes on fall, is sampled on rise
//  fsync        out  1          frame sync, changes only with bclk falling
//  bclk_rise    out  1          1-clk strobe, coincident with bclk going 0->1
//  bclk_fall    out  1          1-clk strobe, coincident with bclk going 1->0
//  bit_idx      out  5          bit position within slot, 0..SLOT_BITS-1 (0 = MSB)
//  slot_idx     out  4          slot position, 0..slots-1
//  frame_start  out  1          1-clk strobe when slot 0, bit 0 becomes current
//  running      out  1          1 while in RUN state
//  cfg_err      out  1          sticky; set when an illegal tdm_num is latched; cleared by reset
// BEHAVIOUR
//  Reset values: all outputs 0. FSM is IDLE; div/bit/slot counters are 0.
//  IDLE: enable sampled 1 -> next cycle goes to RUN. On that cycle:
//   - latch bclk_div, tdm_num and fsync_mode
//   - bclk=0, bit_idx=0, slot_idx=0, frame_start=1
//   - fsync=1 (in both modes)
//  RUN: half-period counter counts 0..div_l; at the terminal count it wraps and bclk toggles.
//   - First bclk rise occurs div_l+1 cycles after entering RUN. Full BCLK period = 2*(div_l+1) clk.
//   - bclk_div=0 gives BCLK = clk/2, with the strobes high every other cycle.
//   - On each bclk fall: bit_idx++. At SLOT_BITS-1, bit_idx wraps to 0 and slot_idx++.
//   - At slot wrap (slots_l-1 -> 0): frame_start=1 and config is re-latched in the same cycle.
//  fsync, updated on the fall edge for the new position:
//   - mode 0: 1 iff slot_idx==0 && bit_idx==0
//   - mode 1: 1 iff slot_idx < slots_l/2
//  enable deasserted in RUN: the current frame completes. At the frame wrap the FSM goes to IDLE
//   instead of frame_start; bclk and fsync are 0, running=0. The frame in progress is never truncated.
//  enable reasserted before the wrap: the deassert is forgotten and running continues seamlessly.
//  Config inputs changing mid-frame have no effect until the next frame wrap. No glitches on bclk.
//  Illegal tdm_num (not 2/4/8/16): the 2-slot count is used and cfg_err is set.
//  Async reset mid-frame: outputs go to 0 immediately. Restart requires enable seen high in IDLE.
//  Latency: bclk/fsync/strobes are registered outputs, with no combinational path from inputs.
// STRUCTURE
//  Shared header head.vh holds:
//   - legal slot-count constants (`TDM_SLOTS_2/4/8/16)
//   - FSM state encodings (IDLE, RUN)
//  Sub-module bclk_divider: half-period counter and bclk toggle. Inputs are div_l and run.
//   Outputs are bclk, bclk_rise and bclk_fall.
//  The top level holds the FSM, bit/slot counters, config latch and fsync decode.
// TESTING
//  1. bclk_div=1, tdm_num=2, mode 1, enable=1 -> BCLK period 4 clk and 64 BCLK per frame.
//     fsync high for slot 0 only (32 BCLK). frame_start every 256 clk.
//  2. bclk_div=0, tdm_num=8, mode 0 -> 256 BCLK/frame.
//     fsync high for exactly one BCLK at slot0/bit0. slot_idx runs 0..7 and wraps to 0.
//  3. tdm_num changed 4->16 mid-frame -> current frame finishes at 128 BCLK. Next frame is 512 BCLK.
//  4. enable dropped at slot 1 of 4 -> slots 2 and 3 complete. Then running=0, bclk=0, no frame_start.
//  5. tdm_num=5 -> cfg_err=1 after latch, 64-BCLK frames. cfg_err stays 1 until rst_n.
//  6. rst_n pulsed low mid-slot 3 -> all outputs 0 asynchronously.
//     Restart gives frame_start with fsync=1 and bit/slot 0.

Source files
------------

// File: rtl/tdm_frame_gen_pkg.sv
// Shared constants, FSM encoding and slot-count decode for the TDM frame generator.
package tdm_frame_gen_pkg;

    localparam int unsigned TDM_SLOTS_2  = 2;
    localparam int unsigned TDM_SLOTS_4  = 4;
    localparam int unsigned TDM_SLOTS_8  = 8;
    localparam int unsigned TDM_SLOTS_16 = 16;

    localparam int unsigned TDM_NUM_W  = 5;
    localparam int unsigned SLOT_IDX_W = 4;
    localparam int unsigned BIT_IDX_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [TDM_NUM_W-1:0] slots;
        logic                 legal;
    } slots_dec_t;

    // Illegal requests fall back to the 2-slot frame and are flagged.
    function automatic slots_dec_t decode_slots(input logic [TDM_NUM_W-1:0] tdm_num);
        slots_dec_t d;
        d.slots = TDM_NUM_W'(TDM_SLOTS_2);
        d.legal = 1'b0;
        case (tdm_num)
            TDM_NUM_W'(TDM_SLOTS_2),
            TDM_NUM_W'(TDM_SLOTS_4),
            TDM_NUM_W'(TDM_SLOTS_8),
            TDM_NUM_W'(TDM_SLOTS_16): begin
                d.slots = tdm_num;
                d.legal = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tdm_frame_gen_bclk_divider.sv
// BCLK half-period counter: toggles bclk every div_l+1 clk cycles while run is high.
module tdm_frame_gen_bclk_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div_l,
    output logic             bclk,
    output logic             bclk_rise,
    output logic             bclk_fall,
    output logic             fall_c
);

    logic [DIV_W-1:0] cnt;
    logic             tick_c;

    assign tick_c = run && (cnt == div_l);
    // Tells the parent that the coming edge is a bclk fall, so positions move with it.
    assign fall_c = tick_c && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bclk      <= 1'b0;
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;
        end else if (!run) begin
            cnt       <= '0;
            bclk      <= 1'b0;
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;
        end else begin
            bclk_rise <= tick_c && !bclk;
            bclk_fall <= tick_c && bclk;
            if (tick_c) begin
                cnt  <= '0;
                bclk <= ~bclk;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tdm_frame_gen.sv
// Master-mode TDM/I2S frame timing generator: FSM, bit/slot counters, config latch, fsync decode.
module tdm_frame_gen
    import tdm_frame_gen_pkg::*;
#(
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned DIV_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      bclk_div,
    input  logic [TDM_NUM_W-1:0]  tdm_num,
    input  logic                  fsync_mode,
    output logic                  bclk,
    output logic                  fsync,
    output logic                  bclk_rise,
    output logic                  bclk_fall,
    output logic [BIT_IDX_W-1:0]  bit_idx,
    output logic [SLOT_IDX_W-1:0] slot_idx,
    output logic                  frame_start,
    output logic                  running,
    output logic                  cfg_err
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(SLOT_BITS - 1);

    state_e                 state;
    state_e                 state_nx;
    logic [DIV_W-1:0]       div_l;
    logic [TDM_NUM_W-1:0]   slots_l;
    logic                   mode_l;
    slots_dec_t             dec;

    logic                   fall_c;
    logic                   run_c;
    logic                   last_slot_c;
    logic                   wrap_c;
    logic                   start_c;
    logic                   latch_c;
    logic [BIT_IDX_W-1:0]   bit_nx;
    logic [SLOT_IDX_W-1:0]  slot_nx;
    logic                   fsync_nx;
    logic                   frame_start_nx;
    logic                   running_nx;

    assign dec         = decode_slots(tdm_num);
    assign run_c       = (state == ST_RUN);
    assign last_slot_c = ({1'b0, slot_idx} == (slots_l - TDM_NUM_W'(1)));
    assign wrap_c      = fall_c && (bit_idx == LAST_BIT) && last_slot_c;
    // A new frame begins either from IDLE or at a wrap while still enabled.
    assign start_c     = enable && ((state == ST_IDLE) || wrap_c);

    tdm_frame_gen_bclk_divider #(
        .DIV_W (DIV_W)
    ) u_bclk_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run_c),
        .div_l     (div_l),
        .bclk      (bclk),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall),
        .fall_c    (fall_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: stopping is decided only at the frame wrap, so frames are never truncated.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (enable) state_nx = ST_RUN;
            ST_RUN:  if (wrap_c && !enable) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered position/fsync outputs.
    always_comb begin
        bit_nx         = bit_idx;
        slot_nx        = slot_idx;
        fsync_nx       = fsync;
        frame_start_nx = 1'b0;
        latch_c        = 1'b0;
        running_nx     = (state_nx == ST_RUN);
        if (start_c) begin
            bit_nx         = '0;
            slot_nx        = '0;
            fsync_nx       = 1'b1;
            frame_start_nx = 1'b1;
            latch_c        = 1'b1;
        end else if (wrap_c) begin
            bit_nx   = '0;
            slot_nx  = '0;
            fsync_nx = 1'b0;
        end else if (fall_c) begin
            if (bit_idx == LAST_BIT) begin
                bit_nx  = '0;
                slot_nx = slot_idx + SLOT_IDX_W'(1);
            end else begin
                bit_nx = bit_idx + BIT_IDX_W'(1);
            end
            if (mode_l) begin
                fsync_nx = ({1'b0, slot_nx} < (slots_l >> 1));
            end else begin
                fsync_nx = (slot_nx == '0) && (bit_nx == '0);
            end
        end
    end

    // Output and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx     <= '0;
            slot_idx    <= '0;
            fsync       <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            cfg_err     <= 1'b0;
            div_l       <= '0;
            slots_l     <= '0;
            mode_l      <= 1'b0;
        end else begin
            bit_idx     <= bit_nx;
            slot_idx    <= slot_nx;
            fsync       <= fsync_nx;
            frame_start <= frame_start_nx;
            running     <= running_nx;
            if (latch_c) begin
                div_l   <= bclk_div;
                slots_l <= dec.slots;
                mode_l  <= fsync_mode;
                if (!dec.legal) cfg_err <= 1'b1;
            end
        end
    end

endmodule
